// File: rtl/magnitude_cmp_pkg.sv
// Shared types for the magnitude-comparator statistics layer: run states whose
// encoding doubles as the software-visible streak_kind value.
package magnitude_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_EQ = 2'd1,
    RUN_GT = 2'd2,
    RUN_LT = 2'd3
  } state_e;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_EQ   = 2'd1;
  localparam logic [1:0] KIND_GT   = 2'd2;
  localparam logic [1:0] KIND_LT   = 2'd3;

  localparam int         STREAK_MAX   = 255;
  localparam logic [7:0] STREAK_MAX_V = 8'(STREAK_MAX);

  // Maps a one-hot flag triple to the run state it would start or extend.
  function automatic state_e kind_of(input logic eq, input logic gt, input logic lt);
    state_e k;
    k = IDLE;
    if (eq)      k = RUN_EQ;
    else if (gt) k = RUN_GT;
    else if (lt) k = RUN_LT;
    return k;
  endfunction

endpackage

// File: rtl/magnitude_stat_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/magnitude_stat_tracker.sv
// Statistics/monitor stage behind the 8-bit magnitude comparator: per-outcome
// saturating counts, current-run tracking and a persistent-inequality alarm.
module magnitude_stat_tracker
  import magnitude_cmp_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A_eq_B,
  input  logic             A_gt_B,
  input  logic             A_lt_B,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [7:0]       streak,
  output logic [1:0]       streak_kind,
  output logic             alarm,
  output logic             out_valid,
  output logic             sample_err
);

  localparam logic [7:0] RUN_LEN_V = 8'(RUN_LEN);

  state_e     state_q, state_d, sample_kind;
  logic [7:0] streak_q, streak_d;
  logic       alarm_q, alarm_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic       onehot, accept;

  always_comb begin
    case ({A_eq_B, A_gt_B, A_lt_B})
      3'b100, 3'b010, 3'b001: onehot = 1'b1;
      default:                onehot = 1'b0;
    endcase
  end

  // Clear discards any same-cycle sample, so it also masks accept and error.
  assign accept      = in_valid && onehot && !clear;
  assign sample_kind = kind_of(A_eq_B, A_gt_B, A_lt_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= 8'd0;
      alarm_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      alarm_q     <= alarm_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (clear) begin
      state_d  = IDLE;
      streak_d = 8'd0;
    end else if (accept) begin
      if (state_q == sample_kind) begin
        if (streak_q != STREAK_MAX_V) streak_d = streak_q + 8'd1;
      end else begin
        state_d  = sample_kind;
        streak_d = 8'd1;
      end
    end
  end

  // Alarm is evaluated on the next state so it lands in the same cycle as the run update.
  always_comb begin
    alarm_d     = ((state_d == RUN_GT) || (state_d == RUN_LT)) && (streak_d >= RUN_LEN_V);
    out_valid_d = accept;
    err_d       = in_valid && !onehot && !clear;
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt_eq (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(accept && A_eq_B), .count(cnt_eq)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_gt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(accept && A_gt_B), .count(cnt_gt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_lt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(accept && A_lt_B), .count(cnt_lt)
  );

  assign streak      = streak_q;
  assign streak_kind = state_q;
  assign alarm       = alarm_q;
  assign out_valid   = out_valid_q;
  assign sample_err  = err_q;

endmodule

// File: tb/tb_magnitude_stat_tracker.sv
// Directed bench for magnitude_stat_tracker (CNT_W=4 so saturation is reachable).
module tb_magnitude_stat_tracker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          A_eq_B = 1'b0, A_gt_B = 1'b0, A_lt_B = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] cnt_eq, cnt_gt, cnt_lt;
  logic [7:0]    streak;
  logic [1:0]    streak_kind;
  logic          alarm, out_valid, sample_err;

  int total = 0;
  int bad   = 0;

  magnitude_stat_tracker #(.CNT_W(CW), .RUN_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A_eq_B(A_eq_B), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B), .clear(clear),
    .cnt_eq(cnt_eq), .cnt_gt(cnt_gt), .cnt_lt(cnt_lt),
    .streak(streak), .streak_kind(streak_kind), .alarm(alarm),
    .out_valid(out_valid), .sample_err(sample_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs applied; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [2:0] f, input logic clr);
    in_valid = v;
    {A_eq_B, A_gt_B, A_lt_B} = f;
    clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {A_eq_B, A_gt_B, A_lt_B} = 3'b000;
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_eq"}, 32'(cnt_eq), 0);
    chk({tag, "_cnt_gt"}, 32'(cnt_gt), 0);
    chk({tag, "_cnt_lt"}, 32'(cnt_lt), 0);
    chk({tag, "_streak"}, 32'(streak), 0);
    chk({tag, "_kind"}, 32'(streak_kind), 0);
    chk({tag, "_alarm"}, 32'(alarm), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_sample_err"}, 32'(sample_err), 0);
  endtask

  localparam logic [2:0] EQ = 3'b100, GT = 3'b010, LT = 3'b001;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Mixed outcomes EQ, GT, LT, GT
    step(1, EQ, 0); chk("mix_ov1", 32'(out_valid), 1);
    step(1, GT, 0); chk("mix_ov2", 32'(out_valid), 1);
    step(1, LT, 0); chk("mix_ov3", 32'(out_valid), 1);
    step(1, GT, 0); chk("mix_ov4", 32'(out_valid), 1);
    chk("mix_cnt_eq", 32'(cnt_eq), 1);
    chk("mix_cnt_gt", 32'(cnt_gt), 2);
    chk("mix_cnt_lt", 32'(cnt_lt), 1);
    chk("mix_streak", 32'(streak), 1);
    chk("mix_kind", 32'(streak_kind), 2);
    chk("mix_alarm", 32'(alarm), 0);
    step(0, GT, 0);
    chk("idle_ov", 32'(out_valid), 0);
    chk("idle_cnt_gt", 32'(cnt_gt), 2);

    // Five LT samples: alarm after the 4th
    step(1, LT, 0); chk("lt1_streak", 32'(streak), 1); chk("lt1_kind", 32'(streak_kind), 3);
    step(1, LT, 0);
    step(1, LT, 0); chk("lt3_alarm", 32'(alarm), 0); chk("lt3_streak", 32'(streak), 3);
    step(1, LT, 0); chk("lt4_alarm", 32'(alarm), 1);
    step(1, LT, 0); chk("lt5_alarm", 32'(alarm), 1); chk("lt5_streak", 32'(streak), 5);
    chk("lt5_cnt_lt", 32'(cnt_lt), 6);
    step(1, EQ, 0);
    chk("eq_after_alarm", 32'(alarm), 0);
    chk("eq_after_streak", 32'(streak), 1);
    chk("eq_after_kind", 32'(streak_kind), 1);
    chk("eq_after_cnt_eq", 32'(cnt_eq), 2);

    // Rejected samples between two GTs
    step(1, GT, 0); chk("err_gt1_streak", 32'(streak), 1);
    step(1, 3'b110, 0);
    chk("err1_pulse", 32'(sample_err), 1);
    chk("err1_ov", 32'(out_valid), 0);
    chk("err1_cnt_gt", 32'(cnt_gt), 3);
    chk("err1_cnt_eq", 32'(cnt_eq), 2);
    step(1, 3'b000, 0);
    chk("err2_pulse", 32'(sample_err), 1);
    chk("err2_streak", 32'(streak), 1);
    step(1, GT, 0);
    chk("err_gt2_streak", 32'(streak), 2);
    chk("err_gt2_err", 32'(sample_err), 0);
    chk("err_gt2_cnt_gt", 32'(cnt_gt), 4);
    chk("err_gt2_kind", 32'(streak_kind), 2);

    // Build cnt_gt to 7, then clear against a same-cycle GT
    step(1, GT, 0); step(1, GT, 0); step(1, GT, 0);
    chk("pre_clr_cnt_gt", 32'(cnt_gt), 7);
    chk("pre_clr_streak", 32'(streak), 5);
    chk("pre_clr_alarm", 32'(alarm), 1);
    step(1, GT, 1);
    chk_all_zero("clear");

    // Counter and streak saturation
    for (int i = 0; i < 17; i++) step(1, EQ, 0);
    chk("sat17_cnt_eq", 32'(cnt_eq), 15);
    chk("sat17_ov", 32'(out_valid), 1);
    chk("sat17_streak", 32'(streak), 17);
    for (int i = 17; i < 255; i++) step(1, EQ, 0);
    chk("sat255_streak", 32'(streak), 255);
    for (int i = 255; i < 300; i++) step(1, EQ, 0);
    chk("sat300_streak", 32'(streak), 255);
    chk("sat300_kind", 32'(streak_kind), 1);
    chk("sat300_cnt_eq", 32'(cnt_eq), 15);
    chk("sat300_alarm", 32'(alarm), 0);

    // Asynchronous reset during an alarmed GT run
    for (int i = 0; i < 4; i++) step(1, GT, 0);
    chk("pre_rst_alarm", 32'(alarm), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, GT, 0);
    chk("post_rst_streak", 32'(streak), 1);
    chk("post_rst_kind", 32'(streak_kind), 2);
    chk("post_rst_cnt_gt", 32'(cnt_gt), 1);
    chk("post_rst_alarm", 32'(alarm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
